plu_seq_cnt: RTL and testbench
==============================

PLU_SEQ_CNT -- requirements
Module: plu_seq_cnt

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of pipelined compute stages (min 1).
REQ-002 SHALL have parameter ITER_W, default 8, width of the iteration limit and iteration count.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  in  1  run request, sampled in IDLE only.
REQ-006 SHALL have port iter_max  in  ITER_W  iteration limit, captured on start acceptance.
REQ-007 SHALL have port converged  in  1  datapath flag (single nonzero output), sampled in CHECK only.
REQ-008 SHALL have port load_we  out  1  write enable for input-vector and weight registers.
REQ-009 SHALL have port stage_we  out  NUM_STAGES  one-hot stage register write enables.
REQ-010 SHALL have port fb_we  out  1  write stage outputs back into the input register.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port timeout  out  1  run ended on iteration limit without convergence.
REQ-014 SHALL have port iter_cnt  out  ITER_W  completed iteration count.

Function
REQ-015 SHALL implement states IDLE, LOAD, STAGE (with stage index k), CHECK, FEEDBACK, DONE.
REQ-016 SHALL transition IDLE->LOAD when start=1 (accept cycle); otherwise remain in IDLE.
REQ-017 SHALL transition LOAD->STAGE k=0, then STAGE k->k+1, and STAGE k=NUM_STAGES-1 ->CHECK.
REQ-018 SHALL, in CHECK: converged=1 -> DONE, timeout=0; else iter_cnt+1 >= limit -> DONE, timeout=1; else -> FEEDBACK.
REQ-019 SHALL transition FEEDBACK->STAGE k=0, and DONE->IDLE unconditionally.
REQ-020 SHALL drive outputs as Moore decode of the registered state: load_we in LOAD, stage_we[k] in STAGE k, fb_we in FEEDBACK, done in DONE; all others 0.
REQ-021 SHALL treat a captured iter_max of 0 as a limit of 1.
REQ-022 SHALL clear iter_cnt in LOAD and increment it by 1 on every exit from CHECK, saturating at all-ones.
REQ-023 SHALL hold iter_cnt and timeout after DONE until the next accepted start; timeout clears in LOAD.
REQ-024 SHALL ignore start in every state except IDLE, including the DONE cycle.
REQ-025 SHALL have a latency of NUM_STAGES+3 cycles from the accept cycle to done for the first pass, plus NUM_STAGES+2 cycles for each additional iteration.
REQ-026 SHALL ignore iter_max changes after acceptance and ignore converged outside CHECK.

Reset
REQ-027 SHALL, on rst=1, immediately enter IDLE and drive load_we, stage_we, fb_we, busy, done, timeout and iter_cnt to 0, regardless of clock and state.
REQ-028 SHALL accept a start on the first rising edge after rst deasserts, with a full normal run following.

Structure
REQ-029 SHALL place the state enumeration and the state-width constant in shared package plu_pkg.
REQ-030 SHALL use a sub-module plu_seq_stage_dec that converts stage index and a STAGE-valid flag into one-hot stage_we.

Verification (NUM_STAGES=3, ITER_W=8, accept cycle = 0)
REQ-031 SHALL cover iter_max=5 with converged=1 at the first CHECK -> load_we@1; stage_we 001@2, 010@3, 100@4; done@6; iter_cnt=1; timeout=0.
REQ-032 SHALL cover iter_max=4 with converged=0 throughout -> fb_we pulses 3 times; done@21; iter_cnt=4; timeout=1.
REQ-033 SHALL cover iter_max=10 with converged=1 only at the third CHECK -> done@16; iter_cnt=3; timeout=0.
REQ-034 SHALL cover start pulsed during STAGE and in the DONE cycle -> both ignored; start in the following IDLE cycle is accepted; busy stays high for the whole run.
REQ-035 SHALL cover rst asserted mid-cycle during STAGE k=1 -> all outputs 0 before the next edge; state is IDLE; a subsequent start reproduces the REQ-031 timing.
REQ-036 SHALL cover iter_max=0 with converged=0 -> done@6; iter_cnt=1; timeout=1; no fb_we pulse.

Source files
------------

// File: rtl/plu_pkg.sv
// Shared definitions for the PLU sequencer: state encoding and its width.
package plu_pkg;

    localparam int PLU_STATE_W = 3;

    typedef enum logic [PLU_STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_STAGE    = 3'd2,
        ST_CHECK    = 3'd3,
        ST_FEEDBACK = 3'd4,
        ST_DONE     = 3'd5
    } plu_state_e;

endpackage : plu_pkg

// File: rtl/plu_seq_stage_dec.sv
// Stage index decoder: turns the active stage index plus a STAGE-valid flag
// into a one-hot stage write-enable vector (all zero when not valid).
module plu_seq_stage_dec #(
    parameter int NUM_STAGES = 3,
    parameter int IDX_W      = 2
) (
    input  logic [IDX_W-1:0]      stage_idx_i,
    input  logic                  stage_vld_i,
    output logic [NUM_STAGES-1:0] stage_we_o
);

    // One-hot decode of the stage index, gated by the valid flag
    always_comb begin
        stage_we_o = '0;
        for (int unsigned i = 0; i < int'(NUM_STAGES); i++) begin
            stage_we_o[i] = stage_vld_i && (stage_idx_i == IDX_W'(i));
        end
    end

endmodule : plu_seq_stage_dec

// File: rtl/plu_seq_cnt.sv
// PLU iteration sequencer: LOAD, NUM_STAGES compute stages, CHECK, then either
// FEEDBACK for another pass or DONE on convergence / iteration limit.
// All outputs are registered and equal a Moore decode of the current state.
module plu_seq_cnt
    import plu_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ITER_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ITER_W-1:0]     iter_max,
    input  logic                  converged,
    output logic                  load_we,
    output logic [NUM_STAGES-1:0] stage_we,
    output logic                  fb_we,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [ITER_W-1:0]     iter_cnt
);

    localparam int K_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_STAGES - 1);

    plu_state_e              state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [ITER_W-1:0]       limit_q, limit_d;
    logic [ITER_W-1:0]       cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    load_we_q, fb_we_q, busy_q, done_q;
    logic [NUM_STAGES-1:0]   stage_we_q, stage_we_d;
    logic [ITER_W:0]         cnt_next_wide;
    logic [ITER_W-1:0]       cnt_sat_inc;

    // Unclamped next count for the limit test, saturating next count for storage
    assign cnt_next_wide = {1'b0, cnt_q} + {{ITER_W{1'b0}}, 1'b1};
    assign cnt_sat_inc   = (cnt_q == '1) ? cnt_q : cnt_next_wide[ITER_W-1:0];

    // Next-state, stage index, iteration bookkeeping
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        limit_d   = limit_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    // A limit of 0 behaves as a single pass
                    limit_d   = (iter_max == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : iter_max;
                    // Cleared on accept so they already read 0 during LOAD
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_STAGE;
                k_d     = '0;
            end
            ST_STAGE: begin
                if (k_q == K_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_CHECK: begin
                cnt_d = cnt_sat_inc;
                if (converged) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b0;
                end else if (cnt_next_wide >= {1'b0, limit_q}) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_FEEDBACK;
                end
            end
            ST_FEEDBACK: begin
                state_d = ST_STAGE;
                k_d     = '0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    plu_seq_stage_dec #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (K_W)
    ) u_stage_dec (
        .stage_idx_i (k_d),
        .stage_vld_i (state_d == ST_STAGE),
        .stage_we_o  (stage_we_d)
    );

    // State and registered outputs; outputs are decoded from the next state so
    // they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            limit_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            load_we_q  <= 1'b0;
            stage_we_q <= '0;
            fb_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            limit_q    <= limit_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            load_we_q  <= (state_d == ST_LOAD);
            stage_we_q <= stage_we_d;
            fb_we_q    <= (state_d == ST_FEEDBACK);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign load_we  = load_we_q;
    assign stage_we = stage_we_q;
    assign fb_we    = fb_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign iter_cnt = cnt_q;

endmodule : plu_seq_cnt

// File: tb/tb_plu_seq_cnt.sv
// Directed bench for plu_seq_cnt (NUM_STAGES=3, ITER_W=8).
module tb_plu_seq_cnt;

    localparam int NS  = 3;
    localparam int IW  = 8;
    localparam int PER = NS + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] iter_max;
    logic          converged;
    logic          load_we;
    logic [NS-1:0] stage_we;
    logic          fb_we;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [IW-1:0] iter_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plu_seq_cnt #(
        .NUM_STAGES (NS),
        .ITER_W     (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .iter_max  (iter_max),
        .converged (converged),
        .load_we   (load_we),
        .stage_we  (stage_we),
        .fb_we     (fb_we),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .iter_cnt  (iter_cnt)
    );

    typedef struct {
        logic [IW-1:0] iter_max;
        int            conv_at;   // CHECK number that sees converged=1, 0 = never
        int            done_cyc;  // cycle of the done pulse, accept cycle = 0
        logic [IW-1:0] cnt;
        logic          to;
        int            fbs;
        bit            noise;     // drive converged=1 outside CHECK cycles
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // {load_we, stage_we, fb_we, busy, done} expected in cycle c of a run ending at d
    function automatic logic [6:0] exp_out(input int c, input int d);
        int p;
        if (c > d)  return 7'b0;
        if (c == d) return 7'b0000011;
        if (c == 1) return 7'b1000010;
        p = (c - 2) % PER;
        if (p < NS)  return {1'b0, 3'(1 << p), 1'b0, 1'b1, 1'b0};
        if (p == NS) return 7'b0000010;
        return 7'b0000110;
    endfunction

    // Accept in the current cycle, then walk through to the IDLE cycle after done
    task automatic run_vec(input vec_t v, input string tag, input bit pulse);
        int  fbs;
        bit  is_chk;
        int  chk_no;
        start     = 1'b1;
        iter_max  = v.iter_max;
        converged = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        iter_max = ~v.iter_max;
        fbs = 0;
        for (int c = 1; c <= v.done_cyc + 1; c++) begin
            is_chk    = (c >= 2) && (c < v.done_cyc) && (((c - 2) % PER) == NS);
            chk_no    = (c - 2) / PER + 1;
            converged = is_chk ? (chk_no == v.conv_at) : v.noise;
            start     = pulse && (c == 3 || c == v.done_cyc);
            #1;
            chk({tag, "_outs"}, 32'({load_we, stage_we, fb_we, busy, done}), 32'(exp_out(c, v.done_cyc)));
            if (fb_we) fbs++;
            if (c == 1) begin
                chk({tag, "_cnt_load"}, 32'(iter_cnt), 32'd0);
                chk({tag, "_to_load"}, 32'(timeout), 32'd0);
            end
            if (c >= v.done_cyc) begin
                chk({tag, "_cnt"}, 32'(iter_cnt), 32'(v.cnt));
                chk({tag, "_timeout"}, 32'(timeout), 32'(v.to));
            end
            if (c <= v.done_cyc) begin
                @(posedge clk); #1;
            end
        end
        start     = 1'b0;
        converged = 1'b0;
        chk({tag, "_fb_pulses"}, 32'(fbs), 32'(v.fbs));
    endtask

    initial begin
        vecs[0] = '{iter_max: 8'd5,  conv_at: 1, done_cyc: 6,  cnt: 8'd1, to: 1'b0, fbs: 0, noise: 1'b0};
        vecs[1] = '{iter_max: 8'd4,  conv_at: 0, done_cyc: 21, cnt: 8'd4, to: 1'b1, fbs: 3, noise: 1'b0};
        vecs[2] = '{iter_max: 8'd10, conv_at: 3, done_cyc: 16, cnt: 8'd3, to: 1'b0, fbs: 2, noise: 1'b1};
        vecs[3] = '{iter_max: 8'd0,  conv_at: 0, done_cyc: 6,  cnt: 8'd1, to: 1'b1, fbs: 0, noise: 1'b0};
        vecs[4] = '{iter_max: 8'd2,  conv_at: 2, done_cyc: 11, cnt: 8'd2, to: 1'b0, fbs: 1, noise: 1'b0};
        vecs[5] = '{iter_max: 8'd1,  conv_at: 0, done_cyc: 6,  cnt: 8'd1, to: 1'b1, fbs: 0, noise: 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        iter_max  = '0;
        converged = 1'b0;
        #2;
        chk("reset_outs", 32'({load_we, stage_we, fb_we, busy, done}), 32'd0);
        chk("reset_cnt", 32'(iter_cnt), 32'd0);
        chk("reset_to", 32'(timeout), 32'd0);
        #10 rst = 1'b0;

        // Table of complete runs
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Start pulses in STAGE and DONE are ignored; next IDLE start is taken
        run_vec(vecs[0], "ign_start", 1'b1);
        run_vec(vecs[4], "after_ign", 1'b0);

        // Asynchronous reset in the middle of STAGE k=1
        start    = 1'b1;
        iter_max = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_stage", 32'({load_we, stage_we, fb_we, busy, done}), 32'b0010010);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outs", 32'({load_we, stage_we, fb_we, busy, done}), 32'd0);
        chk("midrst_cnt", 32'(iter_cnt), 32'd0);
        chk("midrst_to", 32'(timeout), 32'd0);
        #2 rst = 1'b0;
        run_vec(vecs[0], "post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_plu_seq_cnt
